// File: rtl/bp_pkg.sv
// bp_pkg -- shared definitions for the branch predictor.
//   ctr_e       : 2-bit saturating counter encodings (SNT/WNT predict
//                 not-taken, WT/ST predict taken).
//   CTR_RESET   : counter value loaded on reset (weakly not-taken).
//   BP_ENTRIES  : default number of BTB/BHT entries.
//   BP_GHR_W    : default global history length in bits.
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int BP_GHR_W   = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if -- fetch lookup and branch-resolution bus.
//   master : pipeline side; drives fetch_pc and the upd_* fields, receives
//            the prediction and the redirect request.
//   slave  : predictor side.
//   Signals: fetch_pc, predict_taken, predict_target (lookup);
//            upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
//            upd_pred_target (resolution); mispredict, correct_pc (redirect).
interface branch_predictor_if;

  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        mispredict;
  logic [31:0] correct_pc;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  predict_taken, predict_target, mispredict, correct_pc
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output predict_taken, predict_target, mispredict, correct_pc
  );

endinterface

// File: rtl/bp_sat_counter.sv
// bp_sat_counter -- next-state logic of a 2-bit saturating counter.
//   state      : current counter value
//   taken      : resolved branch outcome
//   next_state : state+1 on taken (stops at ST), state-1 otherwise
//                (stops at SNT)
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != ST) next_state = state + 2'b01;
    end else begin
      if (state != SNT) next_state = state - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor -- direct-mapped BTB plus 2-bit-counter BHT.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : branch_predictor_if.slave (lookup, resolution, redirect)
// Lookup and redirect are combinational; tables update on the clock edge
// of a valid resolution, so a same-cycle lookup sees pre-update state.
// Optional build macro BP_GSHARE_EN: BHT indexed by idx XOR global history,
// history register shifted on every resolved branch (non-speculative).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int GHR_W   = BP_GHR_W
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Parameter sanity: history must fit in the index, table at least 4 deep.
  if (GHR_W > IDX_W || ENTRIES < 4) begin : g_param_out_of_range
  end

  logic             btb_valid  [ENTRIES];
  logic [TAG_W-1:0] btb_tag    [ENTRIES];
  logic [31:0]      btb_target [ENTRIES];
  logic [1:0]       bht        [ENTRIES];

  logic [IDX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic [IDX_W-1:0] fetch_bht_idx, upd_bht_idx;
  logic [1:0]       ctr_next;
  logic             btb_hit;
  logic             unused_pc_bits;

  assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
  assign fetch_tag = bus.fetch_pc[31:IDX_W+2];
  assign upd_idx   = bus.upd_pc[IDX_W+1:2];
  assign upd_tag   = bus.upd_pc[31:IDX_W+2];
  // Instruction-aligned PCs: the byte offset never selects anything.
  assign unused_pc_bits = ^bus.fetch_pc[1:0];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  assign fetch_bht_idx = fetch_idx ^ IDX_W'(ghr);
  assign upd_bht_idx   = upd_idx ^ IDX_W'(ghr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (bus.upd_valid) begin
      ghr <= (ghr << 1) | GHR_W'(bus.upd_taken);
    end
  end
`else
  assign fetch_bht_idx = fetch_idx;
  assign upd_bht_idx   = upd_idx;
`endif

  // ---------------------------------------------------------------- lookup
  assign btb_hit = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);

  always_comb begin
    bus.predict_taken  = 1'b0;
    bus.predict_target = 32'h0;
    if (!rst && btb_hit && bht[fetch_bht_idx][1]) begin
      bus.predict_taken  = 1'b1;
      bus.predict_target = btb_target[fetch_idx];
    end
  end

  // -------------------------------------------------------------- redirect
  always_comb begin
    bus.mispredict = 1'b0;
    bus.correct_pc = 32'h0;
    if (!rst && bus.upd_valid &&
        ((bus.upd_taken != bus.upd_pred_taken) ||
         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)))) begin
      bus.mispredict = 1'b1;
      bus.correct_pc = bus.upd_taken ? bus.upd_target : (bus.upd_pc + 32'd4);
    end
  end

  // ---------------------------------------------------------------- update
  bp_sat_counter u_sat_counter (
    .state      (bht[upd_bht_idx]),
    .taken      (bus.upd_taken),
    .next_state (ctr_next)
  );

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        btb_valid[gi]  <= 1'b0;
        btb_tag[gi]    <= '0;
        btb_target[gi] <= 32'h0;
        bht[gi]        <= CTR_RESET;
      end else if (bus.upd_valid) begin
        if (upd_bht_idx == IDX_W'(gi)) begin
          bht[gi] <= ctr_next;
        end
        // Only taken branches allocate; an aliased entry is overwritten.
        if (bus.upd_taken && (upd_idx == IDX_W'(gi))) begin
          btb_valid[gi]  <= 1'b1;
          btb_tag[gi]    <= upd_tag;
          btb_target[gi] <= bus.upd_target;
        end
      end
    end
  end

endmodule
